// File: rtl/rsa_modexp_arbiter.sv
// ---------------------------------------------------------------------------
// RsaModexpArbiter: shares one modular-exponentiation engine between two
// requesters: requester 0 (encrypt) and requester 1 (decrypt).
//
// Operation
//   IDLE    : on a request, pick a winner and latch its m/e plus the shared n.
//             A lone request wins. When both request, the one not granted
//             last time wins (round-robin).
//   BUSY    : eng_compute is held high and the latched operands stay stable
//             until eng_done arrives.
//   RELEASE : one cycle with eng_compute low, then back to IDLE.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req0/req1             level requests
//   m0/e0, m1/e1, n       operands per requester and the shared modulus
//   done0/done1           one-cycle completion pulse per requester
//   res0/res1             per-requester result registers
//   err0/err1             timeout flag, valid together with done
//   eng_compute           start/hold level to the engine
//   eng_M/eng_e/eng_n     latched operands to the engine
//   eng_C, eng_done       engine result and completion
//   busy, grant           busy outside IDLE; index of current/last grant
//
// Configuration macro
//   RSA_ARB_TIMEOUT_EN    when defined, an operation that runs TIMEOUT_CYCLES
//                         BUSY cycles without eng_done is aborted with err=1.
//                         When undefined, BUSY waits forever and err0/err1
//                         are tied low.
// ---------------------------------------------------------------------------
module rsa_modexp_arbiter #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] m0,
    input  logic [WIDTH-1:0] e0,
    input  logic [WIDTH-1:0] m1,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] n,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] res0,
    output logic [WIDTH-1:0] res1,
    output logic             err0,
    output logic             err1,
    output logic             eng_compute,
    output logic [WIDTH-1:0] eng_M,
    output logic [WIDTH-1:0] eng_e,
    output logic [WIDTH-1:0] eng_n,
    input  logic [WIDTH-1:0] eng_C,
    input  logic             eng_done,
    output logic             busy,
    output logic             grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             lastGrant_q, lastGrant_d;
    logic             grant_q, grant_d;
    logic [WIDTH-1:0] engM_q, engM_d;
    logic [WIDTH-1:0] engE_q, engE_d;
    logic [WIDTH-1:0] engN_q, engN_d;
    logic [WIDTH-1:0] res0_q, res0_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             winner;
    logic             timeoutHit;

    // A tie goes to whoever did not win last time. last_grant comes out of
    // reset as 1, so requester 0 wins the first tie.
    assign winner = (req0 && req1) ? ~lastGrant_q : req1;

`ifdef RSA_ARB_TIMEOUT_EN
    localparam int              CntW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] TermCount = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] count_q, count_d;
    logic            err0_q, err0_d;
    logic            err1_q, err1_d;

    // The counter is zero for the first BUSY cycle. The terminal value
    // therefore marks the last allowed BUSY cycle. eng_done in that same
    // cycle still counts as a normal completion.
    always_comb begin
        count_d = count_q;
        if (state_q == IDLE) begin
            count_d = '0;
        end else if (state_q == BUSY) begin
            count_d = count_q + 1'b1;
        end
    end

    assign timeoutHit = (state_q == BUSY) && (count_q == TermCount);
    assign err0_d     = timeoutHit && !eng_done && !grant_q;
    assign err1_d     = timeoutHit && !eng_done && grant_q;

    // Timeout counter and the error flags that travel with done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    assign err0 = err0_q;
    assign err1 = err1_q;
`else
    assign timeoutHit = 1'b0;
    assign err0       = 1'b0;
    assign err1       = 1'b0;
`endif

    // Next state and datapath. Operands are latched only at grant, so
    // requester-side changes during BUSY have no effect. A timeout pulses
    // done but leaves the result register untouched.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        engM_d      = engM_q;
        engE_d      = engE_q;
        engN_d      = engN_q;
        res0_d      = res0_q;
        res1_d      = res1_q;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d     = winner;
                    lastGrant_d = winner;
                    engM_d      = winner ? m1 : m0;
                    engE_d      = winner ? e1 : e0;
                    engN_d      = n;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (eng_done) begin
                    if (grant_q) begin
                        res1_d  = eng_C;
                        done1_d = 1'b1;
                    end else begin
                        res0_d  = eng_C;
                        done0_d = 1'b1;
                    end
                    state_d = RELEASE;
                end else if (timeoutHit) begin
                    done0_d = !grant_q;
                    done1_d = grant_q;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything except
    // last_grant, which resets to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            grant_q     <= 1'b0;
            engM_q      <= '0;
            engE_q      <= '0;
            engN_q      <= '0;
            res0_q      <= '0;
            res1_q      <= '0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            engM_q      <= engM_d;
            engE_q      <= engE_d;
            engN_q      <= engN_d;
            res0_q      <= res0_d;
            res1_q      <= res1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
        end
    end

    assign eng_compute = (state_q == BUSY);
    assign busy        = (state_q != IDLE);
    assign grant       = grant_q;
    assign eng_M       = engM_q;
    assign eng_e       = engE_q;
    assign eng_n       = engN_q;
    assign res0        = res0_q;
    assign res1        = res1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;

endmodule

// File: tb/tb_rsa_modexp_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for rsa_modexp_arbiter. Directed steps run in one initial block
// against a simple engine model that answers a fixed number of cycles after
// eng_compute rises. The timeout step is built only when
// RSA_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_rsa_modexp_arbiter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req0, req1;
    logic [WIDTH-1:0] m0, e0, m1, e1, n;
    logic             done0, done1, err0, err1;
    logic [WIDTH-1:0] res0, res1;
    logic             eng_compute;
    logic [WIDTH-1:0] eng_M, eng_e, eng_n;
    logic [WIDTH-1:0] eng_C;
    logic             modelDone;
    logic             spuriousDone;
    logic             eng_done;
    logic             busy, grant;

    int               checkCount = 0;
    int               passCount  = 0;
    int               failCount  = 0;
    int               engLatency = 10;
    logic             engRespond = 1'b1;
    logic [WIDTH-1:0] engResult  = '0;
    int               engCnt;
    int               cycles;
    logic             seen;
    logic             expGrants [4];

    assign eng_done = modelDone | spuriousDone;

    rsa_modexp_arbiter #(
        .WIDTH         (WIDTH),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .m0         (m0),
        .e0         (e0),
        .m1         (m1),
        .e1         (e1),
        .n          (n),
        .done0      (done0),
        .done1      (done1),
        .res0       (res0),
        .res1       (res1),
        .err0       (err0),
        .err1       (err1),
        .eng_compute(eng_compute),
        .eng_M      (eng_M),
        .eng_e      (eng_e),
        .eng_n      (eng_n),
        .eng_C      (eng_C),
        .eng_done   (eng_done),
        .busy       (busy),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    // Engine model: once eng_compute is seen high, count engLatency edges,
    // then return engResult with a single eng_done pulse.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            engCnt    <= 0;
            modelDone <= 1'b0;
            eng_C     <= '0;
        end else begin
            modelDone <= 1'b0;
            if (eng_compute && !modelDone && engRespond) begin
                if (engCnt == engLatency - 1) begin
                    modelDone <= 1'b1;
                    eng_C     <= engResult;
                    engCnt    <= 0;
                end else begin
                    engCnt <= engCnt + 1;
                end
            end else if (!eng_compute) begin
                engCnt <= 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r0, input logic r1,
                                 input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                 input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                                 input logic [WIDTH-1:0] modN);
        req0 = r0;
        req1 = r1;
        m0   = a0;
        e0   = b0;
        m1   = a1;
        e1   = b1;
        n    = modN;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle at a time until a done pulse appears or the budget
    // is used up.
    task automatic waitDone(input int budget, output int nCycles, output logic found);
        found   = 1'b0;
        nCycles = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (done0 || done1) begin
                found   = 1'b1;
                nCycles = i;
                break;
            end
        end
    endtask

    initial begin
        spuriousDone = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        expGrants = '{1'b0, 1'b1, 1'b0, 1'b1};
        repeat (2) tick();
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstCompute", eng_compute, 0);
        reset = 1'b0;

        // Single request: m0=67, e0=71, n=323, engine answers 0xAB.
        $display("[TB] single request");
        engLatency = 10;
        engResult  = 32'hAB;
        applyStimulus(1, 0, 67, 71, 0, 0, 323);
        checkOutput("computeBeforeSample", eng_compute, 0);
        tick();
        checkOutput("computeAfterSample", eng_compute, 1);
        checkOutput("busyHigh", busy, 1);
        checkOutput("grant0", grant, 0);
        checkOutput("engM", eng_M, 67);
        checkOutput("engE", eng_e, 71);
        checkOutput("engN", eng_n, 323);
        applyStimulus(0, 0, 5, 71, 0, 0, 323);
        tick();
        checkOutput("engMStable", eng_M, 67);
        waitDone(40, cycles, seen);
        checkOutput("done0Seen", seen, 1);
        checkOutput("done0", done0, 1);
        checkOutput("done1Quiet", done1, 0);
        checkOutput("err0", err0, 0);
        checkOutput("res0", res0, 32'hAB);
        checkOutput("res1Zero", res1, 0);
        checkOutput("engMAtDone", eng_M, 67);
        checkOutput("computeReleased", eng_compute, 0);
        tick();
        checkOutput("done0OnePulse", done0, 0);
        checkOutput("idleAfterRelease", busy, 0);

        // Spurious eng_done in IDLE.
        $display("[TB] spurious done");
        spuriousDone = 1'b1;
        tick();
        spuriousDone = 1'b0;
        checkOutput("spurDone0", done0, 0);
        checkOutput("spurDone1", done1, 0);
        checkOutput("spurBusy", busy, 0);
        checkOutput("spurRes0", res0, 32'hAB);
        checkOutput("spurRes1", res1, 0);

        // Reset clears everything, then a tie with both held high.
        $display("[TB] tie and round robin");
        reset = 1'b1;
        #1;
        checkOutput("rstRes0", res0, 0);
        checkOutput("rstEngM", eng_M, 0);
        checkOutput("rstGrant", grant, 0);
        tick();
        reset = 1'b0;
        engLatency = 3;
        applyStimulus(1, 1, 32'h11, 32'h3, 32'h22, 32'h5, 323);
        for (int op = 0; op < 4; op++) begin
            engResult = 32'h100 + op;
            tick();
            checkOutput("rrGrant", grant, expGrants[op]);
            checkOutput("rrEngM", eng_M, expGrants[op] ? 32'h22 : 32'h11);
            waitDone(20, cycles, seen);
            checkOutput("rrDoneSeen", seen, 1);
            checkOutput("rrDone0", done0, !expGrants[op]);
            checkOutput("rrDone1", done1, expGrants[op]);
            tick();
            checkOutput("rrIdle", busy, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("rrRes0", res0, 32'h102);
        checkOutput("rrRes1", res1, 32'h103);

        // Reset three cycles into BUSY, then a fresh req1.
        $display("[TB] reset mid operation");
        engLatency = 10;
        applyStimulus(0, 1, 0, 0, 32'h9, 32'h3, 323);
        tick();
        checkOutput("midGrant", grant, 1);
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midCompute", eng_compute, 0);
        checkOutput("midBusy", busy, 0);
        checkOutput("midGrantZero", grant, 0);
        checkOutput("midRes0", res0, 0);
        checkOutput("midRes1", res1, 0);
        checkOutput("midEngN", eng_n, 0);
        checkOutput("midDone1", done1, 0);
        tick();
        reset = 1'b0;
        engResult = 32'h77;
        tick();
        checkOutput("freshGrant", grant, 1);
        checkOutput("freshEngM", eng_M, 32'h9);
        waitDone(40, cycles, seen);
        checkOutput("freshDoneSeen", seen, 1);
        checkOutput("freshDone1", done1, 1);
        checkOutput("freshErr1", err1, 0);
        checkOutput("freshRes1", res1, 32'h77);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("freshIdle", busy, 0);

`ifdef RSA_ARB_TIMEOUT_EN
        // Engine never answers: abort after 20 BUSY cycles.
        $display("[TB] timeout");
        engRespond = 1'b0;
        applyStimulus(0, 1, 0, 0, 32'h4, 32'h4, 323);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        waitDone(60, cycles, seen);
        checkOutput("toSeen", seen, 1);
        checkOutput("toCycles", cycles, 20);
        checkOutput("toDone1", done1, 1);
        checkOutput("toErr1", err1, 1);
        checkOutput("toRes1Kept", res1, 32'h77);
        tick();
        checkOutput("toErrPulse", err1, 0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_arbiter.md
RSA_MODEXP_ARBITER -- requirements
Module: rsa_modexp_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum BUSY cycles before abort; it is used only under RSA_ARB_TIMEOUT_EN.
REQ-003 clk  in  1  single system clock; all logic is rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req0, req1  in  1 each  level request from requester 0 (encrypt) and requester 1 (decrypt).
REQ-006 m0, e0, m1, e1  in  WIDTH each  message and exponent of each requester.
REQ-007 n  in  WIDTH  shared modulus.
REQ-008 done0, done1  out  1 each  one-cycle completion pulse per requester.
REQ-009 res0, res1  out  WIDTH each  per-requester result register.
REQ-010 err0, err1  out  1 each  timeout flag per requester, valid with done.
REQ-011 eng_compute  out  1  level start and hold to the shared modexp engine.
REQ-012 eng_M, eng_e, eng_n  out  WIDTH each  latched operands to the engine.
REQ-013 eng_C  in  WIDTH  engine result.
REQ-014 eng_done  in  1  engine completion.
REQ-015 busy, grant  out  1 each  busy is high outside IDLE; grant is the index of the current or last granted requester.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and RELEASE.
REQ-017 IDLE SHALL behave as follows:
- If any req is sampled high, select a winner, latch its m/e and n into eng_M/eng_e/eng_n, set grant, and go to BUSY.
- eng_compute SHALL be high from the first BUSY cycle, one cycle after the req sample.
REQ-018 Arbitration SHALL work as follows:
- A single request wins outright.
- If both are high, the requester not granted last wins (round-robin).
- last_grant resets to 1, so requester 0 wins the first tie.
REQ-019 BUSY SHALL hold eng_compute=1 and keep the operands stable; requester operand or req changes SHALL be ignored.
REQ-020 On eng_done sampled high in BUSY, the block SHALL:
- Register eng_C into res[grant].
- Pulse done[grant] for exactly the next cycle, with err[grant]=0.
- Drop eng_compute and enter RELEASE.
REQ-021 RELEASE SHALL last exactly one cycle with eng_compute=0, then return to IDLE.
REQ-022 Requesters SHALL deassert req on the edge that samples done; a req still high in IDLE SHALL be treated as a new request.
REQ-023 A req dropped during BUSY SHALL NOT abort the operation; done and res SHALL still be produced.
REQ-024 eng_done high in IDLE or RELEASE SHALL be ignored.
REQ-025 The non-granted res SHALL hold its value; each res SHALL hold until overwritten by that requester's next completion.
REQ-026 done0 and done1 SHALL never be high in the same cycle.
REQ-027 Back-to-back arbitration: with both reqs continuously high, grants SHALL alternate 0,1,0,1, with one RELEASE cycle between operations.

Reset
REQ-028 Asserting reset SHALL asynchronously force the following, including mid-BUSY:
- state to IDLE and last_grant to 1;
- all outputs to 0: eng_compute, done*, err*, res*, eng_M/e/n, busy, grant.
REQ-029 After reset deasserts, the first req SHALL be sampled on the first rising clk edge with reset low.

Configuration
REQ-030 With RSA_ARB_TIMEOUT_EN defined, the timeout SHALL behave as follows:
- A counter clears on entry to BUSY and increments each BUSY cycle.
- When it reaches TIMEOUT_CYCLES without eng_done, the block pulses done[grant] with err[grant]=1, leaves res[grant] unchanged, drops eng_compute and enters RELEASE.
- If eng_done coincides with the terminal count, eng_done SHALL win and err=0.
REQ-031 Without RSA_ARB_TIMEOUT_EN, the block SHALL have no counter, BUSY SHALL wait indefinitely, and err0/err1 SHALL be tied to 0.

Verification
REQ-032 Single request: req0 with m0=67, e0=71, n=323; engine model returns eng_C=0xAB after 10 cycles -> eng_compute rises 1 cycle after req0, eng_M=67, eng_e=71, eng_n=323, done0 pulses once, res0=0xAB, res1=0.
REQ-033 Tie after reset: req0 and req1 high together -> grant=0 first; with both held high, grants alternate 0,1,0,1 across four operations.
REQ-034 Operand stability: change m0 from 67 to 5 during BUSY -> eng_M stays 67 until done0.
REQ-035 Reset mid-operation: assert reset 3 cycles into BUSY -> all outputs 0 immediately; a fresh req1 afterwards is granted and completes normally.
REQ-036 Spurious done: eng_done pulsed in IDLE -> no done0/done1 pulse and res0/res1 unchanged.
REQ-037 Timeout (RSA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20): engine never responds -> done1 and err1 pulse exactly 20 BUSY cycles after grant, and res1 keeps its prior value.
